uart_rx: RTL

Asynchronous serial receiver: 8N1, LSB first, mid-bit sampling from a single system clock. Sits at the pin-facing edge of the design. Converts the `o_tx`-style line driven by a remote transmitter into bytes on a valid/ready stream. It is the receive-side counterpart of the team's `uart_tx` and shares its parameters and bit-timing arithmetic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_counter.sv | 34 +++
 rtl/uart_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM encoding and
// the bit-timing arithmetic both sides must agree on.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 32'd8;

  // Cycles per bit, rounded to nearest so tx and rx share the same error.
  function automatic int unsigned uart_bit_cycles(input int unsigned f,
                                                  input int unsigned baud);
    return (f + baud / 32'd2) / baud;
  endfunction

endpackage

// File: rtl/uart_counter.sv
// Modulo-MOD up-counter with synchronous clear and count enable.
module uart_counter #(
  parameter int unsigned MOD = 32'd16,
  parameter int unsigned W   = 32'd4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_ce,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_r;

  // Count state; clear wins over enable, wraps after MOD-1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_r <= '0;
    end else if (i_clr) begin
      count_r <= '0;
    end else if (i_ce) begin
      if (count_r == W'(MOD - 32'd1)) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign o_count = count_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// single-entry valid/ready output buffer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned F    = 32'd50000000,
  parameter int unsigned BAUD = 32'd115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned N     = uart_bit_cycles(F, BAUD);
  localparam int unsigned H     = N / 32'd2;
  localparam int unsigned CNT_W = $clog2(N);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

  if (N < 32'd4) begin : g_bad_bit_time
    $error("uart_rx: F/BAUD yields fewer than 4 clock cycles per bit");
  end

  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_dly_r;
  uart_state_e      state_r;
  uart_state_e      state_next_s;
  logic [CNT_W-1:0] baud_cnt_s;
  logic [BIT_W-1:0] bit_cnt_s;
  logic             start_edge_s;
  logic             half_done_s;
  logic             bit_done_s;
  logic             last_bit_s;
  logic             baud_clr_s;
  logic             bit_clr_s;
  logic             bit_ce_s;
  logic             shift_en_s;
  logic             byte_ok_s;
  logic             ferr_s;
  logic [7:0]       sh_r;
  logic [7:0]       data_r;
  logic             valid_r;
  logic             ferr_r;
  logic             ovr_r;

  // Line synchroniser plus edge-detect delay; idle-high reset value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_dly_r  <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
      rx_dly_r  <= rx_sync_r;
    end
  end

  assign start_edge_s = rx_dly_r & ~rx_sync_r;

  uart_counter #(
    .MOD (N),
    .W   (CNT_W)
  ) u_baud_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (baud_clr_s),
    .i_ce    (1'b1),
    .o_count (baud_cnt_s)
  );

  uart_counter #(
    .MOD (UART_DATA_BITS),
    .W   (BIT_W)
  ) u_bit_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (bit_clr_s),
    .i_ce    (bit_ce_s),
    .o_count (bit_cnt_s)
  );

  assign half_done_s = (baud_cnt_s == CNT_W'(H - 32'd1));
  assign bit_done_s  = (baud_cnt_s == CNT_W'(N - 32'd1));
  assign last_bit_s  = (bit_cnt_s == BIT_W'(UART_DATA_BITS - 32'd1));

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a high start sample is treated as a glitch
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_edge_s) state_next_s = START;
        else              state_next_s = IDLE;
      end
      START: begin
        if (half_done_s) begin
          if (rx_sync_r) state_next_s = IDLE;
          else           state_next_s = DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (bit_done_s && last_bit_s) state_next_s = STOP;
        else                          state_next_s = DATA;
      end
      STOP: begin
        if (bit_done_s) state_next_s = IDLE;
        else            state_next_s = STOP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: counter control, shift strobe and frame-end strobes
  always_comb begin
    baud_clr_s = 1'b0;
    bit_clr_s  = 1'b1;
    bit_ce_s   = 1'b0;
    shift_en_s = 1'b0;
    byte_ok_s  = 1'b0;
    ferr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        baud_clr_s = 1'b1;
      end
      START: begin
        baud_clr_s = half_done_s;
      end
      DATA: begin
        bit_clr_s  = 1'b0;
        bit_ce_s   = bit_done_s;
        shift_en_s = bit_done_s;
      end
      STOP: begin
        byte_ok_s = bit_done_s & rx_sync_r;
        ferr_s    = bit_done_s & ~rx_sync_r;
      end
      default: begin
        baud_clr_s = 1'b1;
      end
    endcase
  end

  // LSB-first shift register, filled from the MSB side
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_r <= 8'h00;
    end else if (shift_en_s) begin
      sh_r <= {rx_sync_r, sh_r[7:1]};
    end else begin
      sh_r <= sh_r;
    end
  end

  // Single-entry output buffer; a completing byte may refill it on the handshake cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      ferr_r <= ferr_s;
      ovr_r  <= byte_ok_s & valid_r & ~i_ready;
      if (byte_ok_s && (!valid_r || i_ready)) begin
        data_r  <= sh_r;
        valid_r <= 1'b1;
      end else if (valid_r && i_ready) begin
        data_r  <= data_r;
        valid_r <= 1'b0;
      end else begin
        data_r  <= data_r;
        valid_r <= valid_r;
      end
    end
  end

  assign o_data      = data_r;
  assign o_valid     = valid_r;
  assign o_frame_err = ferr_r;
  assign o_overrun   = ovr_r;

endmodule
